// File: rtl/sync_phase_counter.sv
// rtl/sync_phase_counter.sv - carrier-period phase counter realigned by sync pulses
// Judges each sync against the expected period and tracks lock, misses and errors.
module sync_phase_counter #(
  parameter int PERIOD     = 1250,
  parameter int TOL        = 2,
  parameter int LOCK_COUNT = 4,
  parameter int MISS_LIMIT = 2,
  parameter int CNT_W      = $clog2(PERIOD + TOL + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_pulse,
  output logic [CNT_W-1:0] phase_count,
  output logic             period_start,
  output logic             locked,
  output logic [15:0]      sync_err_count
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  localparam logic [CNT_W-1:0]  LAST_PHASE = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  WIN_LO     = CNT_W'(PERIOD - 1 - TOL);
  localparam logic [CNT_W-1:0]  WIN_HI     = CNT_W'(PERIOD - 1 + TOL);
  localparam logic [CNT_W-1:0]  TOL_V      = CNT_W'(TOL);
  localparam logic [CNT_W-1:0]  SINCE_MAX  = {CNT_W{1'b1}};
  localparam logic [GOOD_W-1:0] GOOD_LAST  = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST  = MISS_W'(MISS_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   since_sync;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               err_inc;
  logic               in_window;
  logic               miss;

  assign in_window    = (since_sync >= WIN_LO) && (since_sync <= WIN_HI);
  // A pulse landing exactly on the threshold counts as on time, never as a miss.
  assign miss         = (state_q != ST_UNLOCKED) && (since_sync == WIN_HI) && !sync_pulse;
  assign period_start = (phase_count == '0);
  assign locked       = (state_q == ST_LOCKED);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    miss_d  = miss_q;
    err_inc = 1'b0;
    case (state_q)
      ST_UNLOCKED: begin
        if (sync_pulse) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      ST_ACQUIRE: begin
        if (sync_pulse) begin
          if (in_window) begin
            if (good_q == GOOD_LAST) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end else begin
            good_d  = '0;
            err_inc = 1'b1;
          end
        end else if (miss) begin
          err_inc = 1'b1;
          state_d = ST_UNLOCKED;
        end
      end
      ST_LOCKED: begin
        if (sync_pulse) begin
          if (in_window) begin
            miss_d = '0;
          end else begin
            err_inc = 1'b1;
            state_d = ST_ACQUIRE;
            good_d  = '0;
          end
        end else if (miss) begin
          err_inc = 1'b1;
          if (miss_q == MISS_LAST) begin
            state_d = ST_UNLOCKED;
          end else begin
            miss_d = miss_q + MISS_W'(1);
          end
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_UNLOCKED;
      good_q         <= '0;
      miss_q         <= '0;
      phase_count    <= '0;
      since_sync     <= '0;
      sync_err_count <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      miss_q  <= miss_d;

      if (err_inc && (sync_err_count != 16'hFFFF)) begin
        sync_err_count <= sync_err_count + 16'd1;
      end

      if (sync_pulse || (phase_count == LAST_PHASE)) begin
        phase_count <= '0;
      end else begin
        phase_count <= phase_count + CNT_W'(1);
      end

      // A miss reloads as if an on-time sync had arrived, so misses recur every period.
      if (sync_pulse) begin
        since_sync <= '0;
      end else if (miss) begin
        since_sync <= TOL_V;
      end else if (since_sync != SINCE_MAX) begin
        since_sync <= since_sync + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sync_phase_counter.sv
// tb/tb_sync_phase_counter.sv - directed self-checking bench for sync_phase_counter
module tb_sync_phase_counter;

  localparam int PERIOD     = 16;
  localparam int TOL        = 1;
  localparam int LOCK_COUNT = 3;
  localparam int MISS_LIMIT = 2;
  localparam int CNT_W      = $clog2(PERIOD + TOL + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             sync_pulse;
  logic [CNT_W-1:0] phase_count;
  logic             period_start;
  logic             locked;
  logic [15:0]      sync_err_count;

  int total = 0;
  int bad   = 0;

  sync_phase_counter #(
    .PERIOD    (PERIOD),
    .TOL       (TOL),
    .LOCK_COUNT(LOCK_COUNT),
    .MISS_LIMIT(MISS_LIMIT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sync_pulse    (sync_pulse),
    .phase_count   (phase_count),
    .period_start  (period_start),
    .locked        (locked),
    .sync_err_count(sync_err_count)
  );

  always #5 clk = ~clk;

  task automatic step(input logic pulse);
    sync_pulse = pulse;
    @(posedge clk);
    #1;
    sync_pulse = 1'b0;
  endtask

  task automatic pulse_after(input int idle);
    repeat (idle) step(1'b0);
    step(1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
  endtask

  task automatic lock_up();
    do_reset();
    step(1'b1);
    repeat (3) pulse_after(15);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (phase_count !== '0) begin
      bad++; $display("FAIL reset_phase: got %0d want 0", phase_count);
    end
    total++;
    if (period_start !== 1'b1) begin
      bad++; $display("FAIL reset_period_start: got %b want 1", period_start);
    end
    total++;
    if (locked !== 1'b0) begin
      bad++; $display("FAIL reset_locked: got %b want 0", locked);
    end
    total++;
    if (sync_err_count !== 16'd0) begin
      bad++; $display("FAIL reset_err: got %0d want 0", sync_err_count);
    end
  endtask

  task automatic test_free_run();
    int exp_phase;
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      step(1'b0);
      exp_phase = i % 16;
      total++;
      if (phase_count !== exp_phase[CNT_W-1:0] || period_start !== (exp_phase == 0)) begin
        bad++;
        $display("FAIL free_run_phase cycle %0d: got phase=%0d start=%b want phase=%0d start=%b",
                 i, phase_count, period_start, exp_phase, exp_phase == 0);
      end
      total++;
      if (locked !== 1'b0 || sync_err_count !== 16'd0) begin
        bad++;
        $display("FAIL free_run_status cycle %0d: got locked=%b err=%0d want locked=0 err=0",
                 i, locked, sync_err_count);
      end
    end
  endtask

  task automatic test_acquire();
    do_reset();
    repeat (5) step(1'b0);
    step(1'b1);
    total++;
    if (phase_count !== '0 || locked !== 1'b0) begin
      bad++; $display("FAIL acquire_first: got phase=%0d locked=%b want phase=0 locked=0", phase_count, locked);
    end
    for (int p = 2; p <= 4; p++) begin
      repeat (15) step(1'b0);
      total++;
      if (phase_count !== 5'd15) begin
        bad++; $display("FAIL acquire_prewrap pulse %0d: got phase=%0d want 15", p, phase_count);
      end
      step(1'b1);
      total++;
      if (phase_count !== '0 || period_start !== 1'b1) begin
        bad++; $display("FAIL acquire_realign pulse %0d: got phase=%0d start=%b want 0 1", p, phase_count, period_start);
      end
      total++;
      if (locked !== (p == 4)) begin
        bad++; $display("FAIL acquire_locked pulse %0d: got %b want %b", p, locked, p == 4);
      end
      total++;
      if (sync_err_count !== 16'd0) begin
        bad++; $display("FAIL acquire_err pulse %0d: got %0d want 0", p, sync_err_count);
      end
    end
  endtask

  task automatic test_window_edges();
    lock_up();
    pulse_after(14);
    total++;
    if (locked !== 1'b1 || sync_err_count !== 16'd0 || phase_count !== '0) begin
      bad++; $display("FAIL window_15: got locked=%b err=%0d phase=%0d want 1 0 0", locked, sync_err_count, phase_count);
    end
    pulse_after(16);
    total++;
    if (locked !== 1'b1 || sync_err_count !== 16'd0 || phase_count !== '0) begin
      bad++; $display("FAIL window_17: got locked=%b err=%0d phase=%0d want 1 0 0", locked, sync_err_count, phase_count);
    end
    repeat (17) step(1'b0);
    total++;
    if (locked !== 1'b1 || sync_err_count !== 16'd1 || phase_count !== 5'd1) begin
      bad++; $display("FAIL window_18_miss: got locked=%b err=%0d phase=%0d want 1 1 1", locked, sync_err_count, phase_count);
    end
    step(1'b1);
    total++;
    if (locked !== 1'b0 || sync_err_count !== 16'd2 || phase_count !== '0) begin
      bad++; $display("FAIL window_18_late: got locked=%b err=%0d phase=%0d want 0 2 0", locked, sync_err_count, phase_count);
    end
  endtask

  task automatic test_miss_drop();
    lock_up();
    repeat (16) step(1'b0);
    total++;
    if (sync_err_count !== 16'd0 || locked !== 1'b1) begin
      bad++; $display("FAIL miss_before: got err=%0d locked=%b want 0 1", sync_err_count, locked);
    end
    step(1'b0);
    total++;
    if (sync_err_count !== 16'd1 || locked !== 1'b1) begin
      bad++; $display("FAIL miss_first: got err=%0d locked=%b want 1 1", sync_err_count, locked);
    end
    repeat (15) step(1'b0);
    total++;
    if (sync_err_count !== 16'd1 || locked !== 1'b1) begin
      bad++; $display("FAIL miss_between: got err=%0d locked=%b want 1 1", sync_err_count, locked);
    end
    step(1'b0);
    total++;
    if (sync_err_count !== 16'd2 || locked !== 1'b0 || phase_count !== 5'd1) begin
      bad++; $display("FAIL miss_drop: got err=%0d locked=%b phase=%0d want 2 0 1", sync_err_count, locked, phase_count);
    end
    repeat (50) step(1'b0);
    total++;
    if (sync_err_count !== 16'd2 || locked !== 1'b0) begin
      bad++; $display("FAIL miss_unlocked_quiet: got err=%0d locked=%b want 2 0", sync_err_count, locked);
    end
  endtask

  task automatic test_extra_pulse();
    lock_up();
    pulse_after(5);
    total++;
    if (phase_count !== '0 || sync_err_count !== 16'd1 || locked !== 1'b0) begin
      bad++; $display("FAIL extra_pulse: got phase=%0d err=%0d locked=%b want 0 1 0", phase_count, sync_err_count, locked);
    end
    for (int p = 1; p <= 3; p++) begin
      pulse_after(15);
      total++;
      if (locked !== (p == 3) || sync_err_count !== 16'd1) begin
        bad++; $display("FAIL relock pulse %0d: got locked=%b err=%0d want %b 1", p, locked, sync_err_count, p == 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    lock_up();
    step(1'b1);
    total++;
    if (phase_count !== '0 || sync_err_count !== 16'd1 || locked !== 1'b0) begin
      bad++; $display("FAIL back_to_back: got phase=%0d err=%0d locked=%b want 0 1 0", phase_count, sync_err_count, locked);
    end
  endtask

  task automatic test_reset_mid();
    lock_up();
    repeat (5) begin
      repeat (17) step(1'b0);
      pulse_after(14);
    end
    total++;
    if (sync_err_count !== 16'd5 || locked !== 1'b1) begin
      bad++; $display("FAIL pre_reset: got err=%0d locked=%b want 5 1", sync_err_count, locked);
    end
    repeat (7) step(1'b0);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    total++;
    if (phase_count !== '0 || period_start !== 1'b1 || locked !== 1'b0 || sync_err_count !== 16'd0) begin
      bad++; $display("FAIL mid_reset: got phase=%0d start=%b locked=%b err=%0d want 0 1 0 0",
                      phase_count, period_start, locked, sync_err_count);
    end
    repeat (20) step(1'b0);
    total++;
    if (sync_err_count !== 16'd0 || phase_count !== 5'd4 || locked !== 1'b0) begin
      bad++; $display("FAIL reset_pulse_ignored: got err=%0d phase=%0d locked=%b want 0 4 0",
                      sync_err_count, phase_count, locked);
    end
  endtask

  initial begin
    rst        = 1'b1;
    sync_pulse = 1'b0;
    test_reset();
    test_free_run();
    test_acquire();
    test_window_edges();
    test_miss_drop();
    test_extra_pulse();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_phase_counter.md
# sync_phase_counter

Downstream consumer of the board's synchronised sync pulse: a free-running carrier-period counter that realigns to phase 0 on every sync pulse. It judges each pulse against the expected period, tracks lock and missed syncs, and publishes the phase count and a period-start strobe. The per-channel transducer phase comparators and the period-boundary register updates consume these outputs.

## Interface
- PERIOD, 1250: carrier period in clk cycles (50 MHz / 40 kHz); must be at least 4.
- TOL, 2: allowed sync arrival error in cycles, either side of expected; must satisfy TOL < PERIOD/2.
- LOCK_COUNT, 4: consecutive in-window pulses needed to lock; must be at least 1.
- MISS_LIMIT, 2: consecutive misses that drop lock; must be at least 1.
- CNT_W, $clog2(PERIOD+TOL+1): width of phase and interval counters.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- sync_pulse  in  1  single-cycle pulse, already synchronised to clk, one per sync rising edge.
- phase_count  out  CNT_W  current phase, 0..PERIOD-1.
- period_start  out  1  high exactly when phase_count == 0.
- locked  out  1  high while FSM is in LOCKED.
- sync_err_count  out  16  saturating count of out-of-window pulses and misses.

## Operation
- Reset values: phase_count 0, period_start 1 (phase is 0), locked 0, sync_err_count 0; FSM UNLOCKED; since_sync 0; good_cnt 0; miss_cnt 0.
- Phase counter:
  - Increments every cycle and wraps PERIOD-1 -> 0.
  - Any sync_pulse, in any state, forces phase_count to 0 on the next cycle.
- since_sync counter:
  - Cleared to 0 on the cycle after a pulse, otherwise increments.
  - A pulse is in-window iff PERIOD-1-TOL <= since_sync <= PERIOD-1+TOL at the pulse cycle.
- Miss:
  - Occurs when since_sync == PERIOD-1+TOL and sync_pulse is 0, in ACQUIRE or LOCKED only.
  - On a miss, since_sync reloads to TOL, acting as a virtual on-time sync, so repeated misses are detected every PERIOD cycles.
  - A miss does not alter phase_count.
- FSM:
  - UNLOCKED: any pulse -> ACQUIRE, good_cnt=0. Misses are neither detected nor counted.
  - ACQUIRE, in-window pulse: good_cnt++. When good_cnt reaches LOCK_COUNT -> LOCKED, miss_cnt=0.
  - ACQUIRE, out-of-window pulse: good_cnt=0, err++, stay in ACQUIRE.
  - ACQUIRE, miss: err++ -> UNLOCKED.
  - LOCKED, in-window pulse: miss_cnt=0.
  - LOCKED, out-of-window pulse: err++ -> ACQUIRE, good_cnt=0.
  - LOCKED, miss: err++, miss_cnt++. When miss_cnt reaches MISS_LIMIT -> UNLOCKED.
- sync_err_count saturates at 16'hFFFF and is cleared only by rst.

## Timing
- sync_pulse high at cycle n -> phase_count=0 and period_start=1 at n+1.
- On a lock-completing pulse at n, locked rises at n+1. On a lock-dropping pulse or miss at n, locked falls at n+1. sync_err_count updates at n+1.
- Simultaneous pulse and miss threshold (since_sync == PERIOD-1+TOL with sync_pulse=1): the pulse wins. It is in-window and no miss is counted.
- A pulse arriving on the natural wrap cycle (phase_count == PERIOD-1) yields phase 0 next cycle, the same result as the wrap alone.
- Back-to-back pulses (since_sync=0 on the second) are out-of-window; the second pulse still realigns.
- since_sync saturates at its maximum value in UNLOCKED and never wraps.
- rst asserted mid-operation returns all state and outputs to reset values on the next edge. A sync_pulse coincident with rst is ignored.

## Test plan
Bench parameters: PERIOD=16, TOL=1, LOCK_COUNT=3, MISS_LIMIT=2.
- Reset, then no pulses for 40 cycles -> phase 0..15 wraps cleanly, period_start every 16 cycles, locked=0, sync_err_count=0.
- First pulse at cycle 5, then pulses every 16 cycles -> phase_count=0 each cycle after a pulse; locked=1 the cycle after the 4th pulse (3rd in-window); err=0.
- Locked, pulse intervals 15 and 17 -> in-window, lock held. Interval 18 -> miss at since_sync=16 counted (err=1, miss_cnt=1), then the pulse at since_sync=1 is out-of-window (err=2) -> ACQUIRE, locked=0.
- Locked, pulses stop -> err=1 at 17 cycles past last pulse; err=2 and locked=0 16 cycles later; no further err increments.
- Locked, extra pulse 6 cycles after an on-time pulse -> phase_count=0 next cycle, err=1, locked=0. Clean pulses relock after 3 in-window intervals.
- rst asserted for 1 cycle while locked with err=5 -> all outputs at reset values next cycle. A pulse coincident with rst does not realign.
